// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode encodings and HI/LO multiply-divide definitions
package cpu_pkg;
    typedef enum logic [4:0] {
        ADD   = 5'b00000,
        MULT  = 5'b10000,
        MULTU = 5'b10001,
        DIV   = 5'b10010,
        DIVU  = 5'b10011,
        LUI   = 5'b10100,
        MTLO  = 5'b10101,
        MTHI  = 5'b10110
    } alu_control_t;
    localparam int MULDIV_ITERS = 32;
    typedef enum logic [1:0] {IDLE, RUN, FIX} muldiv_state_t;
endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: decoder-to-execute link for HI/LO-class operations
interface hilo_muldiv_unit_if #(parameter int DATA_WIDTH = 32);
    import cpu_pkg::*;
    logic start;
    alu_control_t alu_control;
    logic LO_write_enable;
    logic HI_write_enable;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic busy;
    logic done;
    modport master (output start, alu_control, LO_write_enable, HI_write_enable, op_a, op_b,
                    input hi, lo, busy, done);
    modport slave (input start, alu_control, LO_write_enable, HI_write_enable, op_a, op_b,
                   output hi, lo, busy, done);
endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add multiply or restoring divide step per cycle on magnitudes
module muldiv_iter_core
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step,
    input  logic                    div_mode,
    input  logic [DATA_WIDTH-1:0]   a_mag,
    input  logic [DATA_WIDTH-1:0]   b_mag,
    output logic [2*DATA_WIDTH-1:0] acc,
    output logic                    last
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(MULDIV_ITERS);
    logic [W-1:0] m_reg;
    logic [CW-1:0] cnt;
    logic div_reg;
    logic [W:0] sum;
    logic [W:0] diff;
    logic [2*W-1:0] nxt;
    assign last = cnt == CW'(MULDIV_ITERS - 1);
    // Multiply consumes multiplier bits from acc's low half; divide shifts the dividend into the remainder.
    always_comb begin
        sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m_reg} : '0);
        diff = acc[2*W-1:W-1] - {1'b0, m_reg};
        nxt = !div_reg ? {sum, acc[W-1:1]} :
              diff[W]  ? {acc[2*W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1};
    end
    // Load magnitudes on accept, then advance one iteration per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            m_reg <= '0;
            cnt <= '0;
            div_reg <= 1'b0;
        end else if (load) begin
            acc <= {{W{1'b0}}, div_mode ? a_mag : b_mag};
            m_reg <= div_mode ? b_mag : a_mag;
            cnt <= '0;
            div_reg <= div_mode;
        end else if (step) begin
            acc <= nxt;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: owns HI/LO, runs iterative MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO
module hilo_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic reset,
    hilo_muldiv_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;
    muldiv_state_t state;
    logic is_mul, is_div, is_signed, a_neg, b_neg, b_zero, accept, last;
    logic mul_r, neg_lo, neg_hi;
    logic [W-1:0] a_mag, b_mag;
    logic [2*W-1:0] acc, res;
    assign bus.busy = state != IDLE;
    // Decode the offered operation and form operand magnitudes for the signed variants.
    always_comb begin
        is_mul = bus.alu_control inside {MULT, MULTU};
        is_div = bus.alu_control inside {DIV, DIVU};
        is_signed = bus.alu_control inside {MULT, DIV};
        a_neg = is_signed & bus.op_a[W-1];
        b_neg = is_signed & bus.op_b[W-1];
        b_zero = bus.op_b == '0;
        a_mag = a_neg ? -bus.op_a : bus.op_a;
        b_mag = b_neg ? -bus.op_b : bus.op_b;
        accept = state == IDLE && bus.start && (is_mul || is_div) && bus.HI_write_enable && bus.LO_write_enable;
    end
    // Unsigned divide-by-zero leaves remainder=|dividend| and quotient=all ones, so restoring the
    // dividend sign on HI and skipping quotient negation yields hi=op_a, lo=0xFFFFFFFF.
    always_comb begin
        res = mul_r ? (neg_lo ? -acc : acc) :
              {neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W], neg_lo ? -acc[W-1:0] : acc[W-1:0]};
    end
    muldiv_iter_core #(.DATA_WIDTH(W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (state == RUN),
        .div_mode (is_div),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc      (acc),
        .last     (last)
    );
    // Sequencer: accept/decode in IDLE, iterate in RUN, correct signs and commit HI/LO in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bus.hi <= '0;
            bus.lo <= '0;
            bus.done <= 1'b0;
            mul_r <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        mul_r <= is_mul;
                        neg_lo <= (a_neg ^ b_neg) & (is_mul | ~b_zero);
                        neg_hi <= a_neg;
                    end else if (bus.start && bus.alu_control == MTHI && bus.HI_write_enable) begin
                        bus.hi <= bus.op_a;
                    end else if (bus.start && bus.alu_control == MTLO && bus.LO_write_enable) begin
                        bus.lo <= bus.op_a;
                    end
                end
                RUN: state <= last ? FIX : RUN;
                FIX: begin
                    {bus.hi, bus.lo} <= res;
                    bus.done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard-driven checks of HI/LO multiply, divide and move operations
module tb_hilo_muldiv_unit;
    import cpu_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    hilo_muldiv_unit_if bus();
    hilo_muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [63:0] model(alu_control_t c, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa = $signed(a);
        logic signed [63:0] sb = $signed(b);
        logic signed [31:0] qa = $signed(a);
        logic signed [31:0] qb = $signed(b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        case (c)
            MULT: return sa * sb;
            MULTU: return {32'b0, a} * {32'b0, b};
            DIVU: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = qa / qb;
                r = qa % qb;
                return {r, q};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic issue(input alu_control_t c, input logic [31:0] a, input logic [31:0] b,
                         input logic hw, input logic lw);
        bus.alu_control = c;
        bus.op_a = a;
        bus.op_b = b;
        bus.HI_write_enable = hw;
        bus.LO_write_enable = lw;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit seen);
        n = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            else if (bus.busy) n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        reset = 1'b0;
    endtask

    task automatic test_mult_latency;
        logic [31:0] old_hi, old_lo;
        logic [63:0] exp;
        int n = 0;
        bit seen = 0;
        bit moved = 0;
        old_hi = bus.hi;
        old_lo = bus.lo;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
        issue(MULT, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            else begin
                if (bus.busy) n++;
                if (bus.hi !== old_hi || bus.lo !== old_lo) moved = 1;
            end
        end
        exp = exp_q.pop_front();
        checks += 4;
        if (n != 33 || !seen) begin errors++; $display("FAIL mult_busy_cycles got=%0d seen=%0b exp=33", n, seen); end
        if (moved) begin errors++; $display("FAIL mult_hilo_hold got=partial exp=unchanged"); end
        if ({bus.hi, bus.lo} !== exp) begin errors++; $display("FAIL mult_result got=%h exp=%h", {bus.hi, bus.lo}, exp); end
        @(negedge clk);
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mult_done_once got done=%b busy=%b exp=0", bus.done, bus.busy);
        end
    endtask

    task automatic test_muldiv_table;
        alu_control_t tc[4] = '{MULTU, DIV, DIVU, DIV};
        logic [31:0] ta[4] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] tb[4] = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [63:0] te[4] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFD,
                               64'h00000007_FFFFFFFF, 64'h00000000_80000000};
        alu_control_t c;
        logic [31:0] a, b;
        logic [63:0] exp;
        int n;
        bit seen;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                c = tc[i]; a = ta[i]; b = tb[i];
                exp_q.push_back(te[i]);
            end else begin
                c = alu_control_t'(5'h10 + 5'($urandom_range(0, 3)));
                a = (i % 3 == 0) ? -32'($urandom_range(1, 1000)) : $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'h0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 50)));
                exp_q.push_back(model(c, a, b));
            end
            issue(c, a, b, 1'b1, 1'b1);
            wait_done(n, seen);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || {bus.hi, bus.lo} !== exp) begin
                errors++;
                $display("FAIL op%0d_%s a=%h b=%h got=%h seen=%0b exp=%h", i, c.name(), a, b, {bus.hi, bus.lo}, seen, exp);
            end
        end
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] old_lo;
        bit activity = 0;
        old_lo = bus.lo;
        bus.alu_control = MTHI; bus.op_a = 32'h12345678; bus.HI_write_enable = 1'b1; bus.LO_write_enable = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (bus.busy || bus.done) activity = 1;
        checks += 3;
        if (bus.hi !== 32'h12345678 || bus.lo !== old_lo) begin
            errors++; $display("FAIL mthi got hi=%h lo=%h exp hi=12345678 lo=%h", bus.hi, bus.lo, old_lo);
        end
        bus.alu_control = MTLO; bus.op_a = 32'h9ABCDEF0; bus.HI_write_enable = 1'b0; bus.LO_write_enable = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        if (bus.busy || bus.done) activity = 1;
        if (bus.lo !== 32'h9ABCDEF0 || bus.hi !== 32'h12345678) begin
            errors++; $display("FAIL mtlo got hi=%h lo=%h exp hi=12345678 lo=9abcdef0", bus.hi, bus.lo);
        end
        @(negedge clk);
        if (bus.busy || bus.done) activity = 1;
        if (activity) begin errors++; $display("FAIL move_quiet got=busy_or_done exp=quiet"); end
    endtask

    task automatic test_ignored;
        logic [31:0] old_hi, old_lo;
        bit active = 0;
        old_hi = bus.hi;
        old_lo = bus.lo;
        issue(ADD, 32'h1, 32'h2, 1'b1, 1'b1);
        active |= bus.busy;
        issue(MULT, 32'h3, 32'h4, 1'b1, 1'b0);
        active |= bus.busy;
        issue(DIVU, 32'h9, 32'h3, 1'b0, 1'b1);
        active |= bus.busy;
        issue(MTHI, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        issue(MTLO, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        repeat (3) begin @(negedge clk); active |= bus.busy | bus.done; end
        checks += 2;
        if (active) begin errors++; $display("FAIL ignored_busy got=active exp=idle"); end
        if (bus.hi !== old_hi || bus.lo !== old_lo) begin
            errors++; $display("FAIL ignored_hilo got=%h_%h exp=%h_%h", bus.hi, bus.lo, old_hi, old_lo);
        end
    endtask

    task automatic test_busy_ignore;
        logic [63:0] exp;
        int n;
        bit seen;
        exp_q.push_back(64'h00000000_0000000C);
        issue(MULTU, 32'd3, 32'd4, 1'b1, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        bus.alu_control = MTLO; bus.op_a = 32'h0000AAAA; bus.HI_write_enable = 1'b0; bus.LO_write_enable = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(n, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || {bus.hi, bus.lo} !== exp) begin
            errors++; $display("FAIL busy_mtlo got=%h seen=%0b exp=%h", {bus.hi, bus.lo}, seen, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] exp;
        int n;
        bit seen;
        bit pulsed = 0;
        issue(DIVU, 32'd100, 32'd7, 1'b1, 1'b1);
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        checks += 3;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL async_reset got hi=%h lo=%h busy=%b exp=0", bus.hi, bus.lo, bus.busy);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) begin @(negedge clk); pulsed |= bus.done | bus.busy; end
        if (pulsed) begin errors++; $display("FAIL reset_discard got=done_or_busy exp=none"); end
        exp_q.push_back(64'h00000002_0000000E);
        issue(DIVU, 32'd100, 32'd7, 1'b1, 1'b1);
        wait_done(n, seen);
        exp = exp_q.pop_front();
        if (!seen || {bus.hi, bus.lo} !== exp) begin
            errors++; $display("FAIL divu_after_reset got=%h seen=%0b exp=%h", {bus.hi, bus.lo}, seen, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp;
        int n;
        bit seen;
        exp_q.push_back(model(MULT, 32'h80000000, 32'h80000000));
        issue(MULT, 32'h80000000, 32'h80000000, 1'b1, 1'b1);
        wait_done(n, seen);
        exp = exp_q.pop_front();
        checks += 3;
        if (!seen || {bus.hi, bus.lo} !== exp) begin
            errors++; $display("FAIL b2b_first got=%h seen=%0b exp=%h", {bus.hi, bus.lo}, seen, exp);
        end
        exp_q.push_back(model(DIV, 32'h7FFFFFFF, 32'hFFFFFFFD));
        issue(DIV, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b1);
        wait_done(n, seen);
        exp = exp_q.pop_front();
        if (n != 33 || !seen) begin errors++; $display("FAIL b2b_latency got=%0d seen=%0b exp=33", n, seen); end
        if ({bus.hi, bus.lo} !== exp) begin
            errors++; $display("FAIL b2b_second got=%h exp=%h", {bus.hi, bus.lo}, exp);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.alu_control = ADD;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.HI_write_enable = 1'b0;
        bus.LO_write_enable = 1'b0;
        test_reset();
        test_mult_latency();
        test_muldiv_table();
        test_mthi_mtlo();
        test_ignored();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage consumer of the decoded `alu_control`, `LO_write_enable` and `HI_write_enable` fields; receiver end of the ALU decoder interface for HI/LO-class operations.
- Owns the architectural HI and LO registers.
- Executes MULT, MULTU, DIV and DIVU iteratively over multiple cycles; executes MTHI and MTLO in a single cycle.
- Exposes `busy` so the pipeline stalls MFHI/MFLO and further HI/LO operations until the result is committed.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Only 32 is supported; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  operation valid this cycle; sampled only when busy=0.
- alu_control  input  5  decoded control code (shared encoding).
- LO_write_enable  input  1  operation targets LO.
- HI_write_enable  input  1  operation targets HI.
- op_a  input  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
- op_b  input  32  rt value: multiplier or divisor.
- hi  output  32  HI register.
- lo  output  32  LO register.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse after a multiply or divide result is committed.

Behaviour:
- Reset (asynchronous, at any time including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, all iteration registers cleared. An in-flight operation is discarded.
- Accept rule: in IDLE, at a clock edge with start=1, the unit decodes the inputs as follows.
  - MULT/MULTU/DIV/DIVU with both write enables set: latch operands, go to RUN.
  - MTHI with HI_write_enable=1: hi<=op_a; stay IDLE; no done pulse.
  - MTLO with LO_write_enable=1: lo<=op_a; stay IDLE; no done pulse.
  - Any other code, or a required enable missing: ignored.
- start while busy=1: ignored, with no error. Upstream must hold the instruction until busy=0.
- States:
  - IDLE.
  - RUN: counter 0..31, one iteration per cycle.
  - FIX: sign correction and commit, 1 cycle.
  - FIX always returns to IDLE.
- Latency:
  - Accept at edge E0; busy high from E0 to E33.
  - hi/lo update at E33; done=1 for exactly the cycle after E33.
  - Earliest back-to-back accept is at E34.
- hi/lo hold their old values throughout RUN/FIX; no partial results are ever visible.
- Multiply: shift-add on 32-bit magnitudes into a 64-bit product; {hi,lo}=product.
  - MULT: magnitudes are absolute values; the product is negated in FIX if operand signs differ.
  - MULTU: raw operands, no correction.
- Divide: restoring division, one quotient bit per cycle; lo=quotient, hi=remainder.
  - DIV: magnitudes are absolute values. The quotient is negated if signs differ; the remainder takes the dividend's sign.
  - DIV overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (DIV or DIVU, op_b=0): hi=op_a, lo=0xFFFFFFFF, with the normal 33-cycle latency and done pulse. No sign correction is applied.
- Simultaneous reset and start: reset wins.
- MTHI/MTLO that arrives while busy: ignored, the same as any other start while busy.

Decomposition:
- Shared package `cpu_pkg` holds:
  - `alu_control_t` with its encodings: ADD=00000 … MULT=10000, MULTU=10001, DIV=10010, DIVU=10011, LUI=10100, MTLO=10101, MTHI=10110. The decoder and this unit both import it; local copies are forbidden.
  - Constant `MULDIV_ITERS` = 32.
  - `muldiv_state_t` {IDLE, RUN, FIX}.
- One sub-module, `muldiv_iter_core`:
  - Owns the magnitude registers, the 64-bit accumulator/remainder and the iteration counter.
  - Performs one step per cycle in multiply or divide mode.
  - Top level keeps the FSM, sign logic, HI/LO registers and the accept decode.

Test Plan:
- MULT op_a=0xFFFFFFFD (-3), op_b=5 → busy for 33 cycles; after E33 hi=0xFFFFFFFF, lo=0xFFFFFFF1; done pulses exactly once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV cases:
  - -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7 / 0 → hi=0x00000007, lo=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → hi/lo update one edge after each; busy and done stay 0.
- Start MULTU 3×4, then assert start with MTLO 0xAAAA at cycle 10 (busy) → MTLO ignored; final hi=0, lo=12.
- Start DIVU 100/7, then assert reset at cycle 15 for 1 cycle → hi=lo=0, busy=0, done never pulses. A new DIVU 100/7 then gives lo=14, hi=2.
